// File: rtl/ram_arb.sv
// ram_arb: round-robin arbiter giving two requesters a 3-cycle access to one single-port RAM
module ram_arb #(
    parameter int DEPTH = 12,
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_a,
    input  logic          req_b,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_a,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_a,
    output logic          ack_b,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          err_a,
    output logic          err_b,
    output logic [AW-1:0] ram_dir,
    output logic [DW-1:0] ram_dato_e,
    output logic          ram_en,
    input  logic [DW-1:0] ram_dato_s
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);
    state_t state, state_nx;
    logic last_b, last_b_nx, sel_b, sel_b_nx, we_l, we_l_nx, ok_l, ok_l_nx;
    logic pick_b, win_we, win_ok;
    logic [AW-1:0] win_addr, dir_nx;
    logic [DW-1:0] win_wdata, dato_nx, rdata_a_nx, rdata_b_nx;
    logic en_nx, ack_a_nx, ack_b_nx, err_a_nx, err_b_nx;
    // B wins only when alone, or on a tie when A was served last
    assign pick_b = req_b & (~req_a | ~last_b);
    assign win_we = pick_b ? we_b : we_a;
    assign win_addr = pick_b ? addr_b : addr_a;
    assign win_wdata = pick_b ? wdata_b : wdata_a;
    assign win_ok = {1'b0, win_addr} < LIMIT;
    always_comb begin
        state_nx = state;
        last_b_nx = last_b;
        sel_b_nx = sel_b;
        we_l_nx = we_l;
        ok_l_nx = ok_l;
        dir_nx = ram_dir;
        dato_nx = ram_dato_e;
        en_nx = 1'b0;
        ack_a_nx = 1'b0;
        ack_b_nx = 1'b0;
        err_a_nx = 1'b0;
        err_b_nx = 1'b0;
        rdata_a_nx = rdata_a;
        rdata_b_nx = rdata_b;
        case (state)
            IDLE: if (req_a || req_b) begin
                state_nx = ACCESS;
                last_b_nx = pick_b;
                sel_b_nx = pick_b;
                we_l_nx = win_we;
                ok_l_nx = win_ok;
                dir_nx = win_addr;
                dato_nx = win_wdata;
                en_nx = win_we & win_ok;
            end
            ACCESS: begin
                state_nx = RESP;
                ack_a_nx = ~sel_b;
                ack_b_nx = sel_b;
                err_a_nx = ~sel_b & ~ok_l;
                err_b_nx = sel_b & ~ok_l;
                rdata_a_nx = (!sel_b && !we_l) ? (ok_l ? ram_dato_s : '0) : rdata_a;
                rdata_b_nx = (sel_b && !we_l) ? (ok_l ? ram_dato_s : '0) : rdata_b;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last_b <= 1'b1;
            sel_b <= 1'b0;
            we_l <= 1'b0;
            ok_l <= 1'b0;
            ram_dir <= '0;
            ram_dato_e <= '0;
            ram_en <= 1'b0;
            ack_a <= 1'b0;
            ack_b <= 1'b0;
            err_a <= 1'b0;
            err_b <= 1'b0;
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            state <= state_nx;
            last_b <= last_b_nx;
            sel_b <= sel_b_nx;
            we_l <= we_l_nx;
            ok_l <= ok_l_nx;
            ram_dir <= dir_nx;
            ram_dato_e <= dato_nx;
            ram_en <= en_nx;
            ack_a <= ack_a_nx;
            ack_b <= ack_b_nx;
            err_a <= err_a_nx;
            err_b <= err_b_nx;
            rdata_a <= rdata_a_nx;
            rdata_b <= rdata_b_nx;
        end
    end
endmodule

// File: tb/tb_ram_arb.sv
// tb_ram_arb: table vectors, hand sequences and random traffic against a memory/round-robin model
module tb_ram_arb;
    localparam int DEPTH = 12;
    logic clk = 1'b0, rst_n = 1'b0, preload = 1'b1;
    logic req_a = 0, req_b = 0, we_a = 0, we_b = 0;
    logic [7:0] addr_a = 0, addr_b = 0, wdata_a = 0, wdata_b = 0;
    logic ack_a, ack_b, err_a, err_b, ram_en;
    logic [7:0] rdata_a, rdata_b, ram_dir, ram_dato_e, ram_dato_s;
    int n_chk = 0, n_fail = 0;
    logic [7:0] mem [256];
    logic [7:0] mdl [256];
    logic m_last_b = 1'b1;
    logic [7:0] m_rd_a = 0, m_rd_b = 0;
    logic s_ack_a, s_ack_b, s_err;
    logic [7:0] s_rd;

    typedef struct {
        logic ra, rb, wa, wb;
        logic [7:0] aa, ab, da, db;
        logic e_b, e_err;
        logic [7:0] e_rd;
    } vec_t;
    vec_t vt [12];

    ram_arb dut (
        .clk(clk), .rst_n(rst_n),
        .req_a(req_a), .req_b(req_b), .we_a(we_a), .we_b(we_b),
        .addr_a(addr_a), .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b),
        .ack_a(ack_a), .ack_b(ack_b), .rdata_a(rdata_a), .rdata_b(rdata_b),
        .err_a(err_a), .err_b(err_b), .ram_dir(ram_dir), .ram_dato_e(ram_dato_e),
        .ram_en(ram_en), .ram_dato_s(ram_dato_s)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] init_val(int i);
        return i < 9 ? 8'(90 - 10 * i) : i < 12 ? 8'(91 + i) : 8'hEE;
    endfunction

    // Shared RAM: combinational read, write on the rising edge while ram_en is high
    assign ram_dato_s = mem[ram_dir];
    always @(posedge clk) begin
        if (preload) for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
        else if (ram_en) mem[ram_dir] <= ram_dato_e;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One full transaction, entered at a falling edge while the arbiter is idle
    task automatic txn(input logic ra, rb, wa, wb, input logic [7:0] aa, ab, da, db);
        logic win_b, w, ok;
        logic [7:0] ad, wd;
        req_a = ra; req_b = rb; we_a = wa; we_b = wb;
        addr_a = aa; addr_b = ab; wdata_a = da; wdata_b = db;
        win_b = rb && (!ra || !m_last_b);
        w = win_b ? wb : wa;
        ad = win_b ? ab : aa;
        wd = win_b ? db : da;
        ok = ad < DEPTH;
        @(negedge clk);
        req_a = 0; req_b = 0;
        we_a = 1'($urandom); we_b = 1'($urandom);
        addr_a = 8'($urandom); addr_b = 8'($urandom);
        wdata_a = 8'($urandom); wdata_b = 8'($urandom);
        chk("access_en", ram_en, w & ok);
        chk("access_dir", ram_dir, ad);
        if (w && ok) chk("access_wdata", ram_dato_e, wd);
        chk("access_quiet", {ack_a, ack_b, err_a, err_b}, 0);
        @(negedge clk);
        if (w && ok) mdl[ad] = wd;
        if (!w && win_b) m_rd_b = ok ? mdl[ad] : 8'h00;
        if (!w && !win_b) m_rd_a = ok ? mdl[ad] : 8'h00;
        m_last_b = win_b;
        chk("resp_ack_a", ack_a, !win_b);
        chk("resp_ack_b", ack_b, win_b);
        chk("resp_err_a", err_a, !win_b && !ok);
        chk("resp_err_b", err_b, win_b && !ok);
        chk("resp_rdata_a", rdata_a, m_rd_a);
        chk("resp_rdata_b", rdata_b, m_rd_b);
        chk("resp_en", ram_en, 0);
        s_ack_a = ack_a; s_ack_b = ack_b; s_err = err_a | err_b;
        s_rd = ack_b ? rdata_b : rdata_a;
        @(negedge clk);
        chk("idle_quiet", {ack_a, ack_b, err_a, err_b, ram_en}, 0);
    endtask

    task automatic idle_cycle();
        req_a = 0; req_b = 0;
        @(negedge clk);
        chk("idle_gap", {ack_a, ack_b, err_a, err_b, ram_en}, 0);
    endtask

    initial begin
        int bad, sel;
        for (int i = 0; i < 256; i++) mdl[i] = init_val(i);
        vt[0]  = '{1, 1, 0, 0, 8'd1,   8'd10,  8'h00, 8'h00, 0, 0, 8'd80};
        vt[1]  = '{1, 0, 0, 0, 8'd3,   8'd0,   8'h00, 8'h00, 0, 0, 8'd60};
        vt[2]  = '{1, 0, 1, 0, 8'd5,   8'd0,   8'h55, 8'h00, 0, 0, 8'd60};
        vt[3]  = '{0, 1, 0, 0, 8'd0,   8'd5,   8'h00, 8'h00, 1, 0, 8'h55};
        vt[4]  = '{0, 1, 0, 1, 8'd0,   8'd12,  8'h00, 8'h77, 1, 1, 8'h55};
        vt[5]  = '{1, 1, 0, 0, 8'd0,   8'd9,   8'h00, 8'h00, 0, 0, 8'd90};
        vt[6]  = '{1, 1, 0, 0, 8'd0,   8'd9,   8'h00, 8'h00, 1, 0, 8'd100};
        vt[7]  = '{1, 0, 0, 0, 8'd200, 8'd0,   8'h00, 8'h00, 0, 1, 8'd0};
        vt[8]  = '{0, 1, 0, 0, 8'd0,   8'd11,  8'h00, 8'h00, 1, 0, 8'd102};
        vt[9]  = '{1, 1, 1, 1, 8'd0,   8'd1,   8'h12, 8'h34, 0, 0, 8'd0};
        vt[10] = '{1, 0, 0, 0, 8'd0,   8'd0,   8'h00, 8'h00, 0, 0, 8'h12};
        vt[11] = '{0, 1, 0, 0, 8'd0,   8'd255, 8'h00, 8'h00, 1, 1, 8'd0};

        @(negedge clk);
        preload = 0;
        chk("reset_flags", {ack_a, ack_b, err_a, err_b, ram_en}, 0);
        chk("reset_rdata", {rdata_a, rdata_b}, 0);
        chk("reset_ram_bus", {ram_dir, ram_dato_e}, 0);

        // Both hold requests from reset release: grants alternate A, B, A, B
        @(negedge clk);
        rst_n = 1;
        req_a = 1; req_b = 1; addr_a = 0; addr_b = 9;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("rr_ack_a", ack_a, k == 2 || k == 8);
            chk("rr_ack_b", ack_b, k == 5 || k == 11);
            if (ack_a) chk("rr_rdata_a", rdata_a, 90);
            if (ack_b) chk("rr_rdata_b", rdata_b, 100);
            if (k == 12) begin req_a = 0; req_b = 0; end
        end
        m_rd_a = 90; m_rd_b = 100; m_last_b = 1;

        // Reset in the middle of a write access
        req_a = 1; we_a = 1; addr_a = 2; wdata_a = 8'hAB;
        @(negedge clk);
        chk("abort_pre_en", ram_en, 1);
        req_a = 0; we_a = 0;
        #1 rst_n = 0;
        #1;
        chk("abort_en_async", ram_en, 0);
        chk("abort_no_ack", {ack_a, ack_b}, 0);
        chk("abort_rdata", {rdata_a, rdata_b}, 0);
        chk("abort_dir", ram_dir, 0);
        @(negedge clk);
        rst_n = 1;
        m_rd_a = 0; m_rd_b = 0; m_last_b = 1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_quiet", {ack_a, ack_b, ram_en}, 0);
        end
        chk("abort_no_write", mem[2], 70);

        for (int v = 0; v < 12; v++) begin
            txn(vt[v].ra, vt[v].rb, vt[v].wa, vt[v].wb, vt[v].aa, vt[v].ab, vt[v].da, vt[v].db);
            chk($sformatf("vec%0d_winner", v), {s_ack_a, s_ack_b}, {!vt[v].e_b, vt[v].e_b});
            chk($sformatf("vec%0d_err", v), s_err, vt[v].e_err);
            chk($sformatf("vec%0d_rdata", v), s_rd, vt[v].e_rd);
        end
        chk("oob_write_blocked", mem[12], 8'hEE);

        for (int t = 0; t < 60; t++) begin
            sel = $urandom_range(1, 3);
            txn(sel[0], sel[1], 1'($urandom), 1'($urandom),
                8'($urandom_range(0, 15)), 8'($urandom_range(0, 15)), 8'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== mdl[i]) bad++;
        chk("ram_contents", bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_arb.md
RAM_ARB -- requirements
Module: ram_arb

Interface
REQ-001 Parameter DEPTH, default 12, number of valid RAM locations (addresses 0..DEPTH-1).
REQ-002 Parameter AW, default 8, address width.
REQ-003 Parameter DW, default 8, data width.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 req_a, req_b  input  1 each  access request from requester A / B.
REQ-007 we_a, we_b  input  1 each  1 = write, 0 = read.
REQ-008 addr_a, addr_b  input  AW each  target address.
REQ-009 wdata_a, wdata_b  input  DW each  write data.
REQ-010 ack_a, ack_b  output  1 each  one-cycle completion pulse.
REQ-011 rdata_a, rdata_b  output  DW each  read data, valid while matching ack is high.
REQ-012 err_a, err_b  output  1 each  one-cycle pulse with ack when address >= DEPTH.
REQ-013 ram_dir  output  AW  address to shared single-port RAM.
REQ-014 ram_dato_e  output  DW  write data to RAM.
REQ-015 ram_en  output  1  RAM write enable (1 = write, 0 = read).
REQ-016 ram_dato_s  input  DW  RAM read data, valid one clock after ram_dir is driven with ram_en = 0.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, RESP; all outputs registered.
REQ-018 IDLE: if any req high, select winner, latch its we/addr/wdata, go ACCESS; else stay IDLE.
REQ-019 Arbitration round-robin: single requester wins; both requesting -> winner is the one not served last; last-served pointer resets to B (A wins first tie).
REQ-020 ACCESS (exactly one cycle): drive ram_dir = latched addr, ram_dato_e = latched wdata, ram_en = latched we AND (addr < DEPTH); go RESP.
REQ-021 Out-of-range address: ram_en SHALL stay 0 (no RAM write), read returns 0.
REQ-022 RESP (exactly one cycle): winner's ack = 1; on in-range read rdata = ram_dato_s captured at end of ACCESS; err = 1 if addr >= DEPTH; ram_en = 0; go IDLE.
REQ-023 Latency: req sampled at edge N (state IDLE) -> ack high during cycle N+2; max throughput one access per 3 cycles.
REQ-024 Requester SHALL hold req, we, addr, wdata stable until its ack; arbiter ignores field changes after the latch.
REQ-025 req deasserted after latch does not abort; the access completes and ack is still issued.
REQ-026 Loser's ack, err remain 0; loser's rdata holds previous value.
REQ-027 ram_en SHALL be 1 only during ACCESS for an in-range write; never in IDLE or RESP.
REQ-028 Requester holding req high after ack is re-arbitrated in the next IDLE cycle (no starvation: with both continuously requesting, grants alternate A, B, A, B).
REQ-029 rdata for writes SHALL hold its previous value.

Reset
REQ-030 rst_n low SHALL immediately force state IDLE, ack_a/b = 0, err_a/b = 0, rdata_a/b = 0, ram_en = 0, ram_dir = 0, ram_dato_e = 0, last-served pointer = B.
REQ-031 Reset asserted during ACCESS or RESP SHALL abort the access with no ack, and ram_en SHALL drop asynchronously.
REQ-032 After rst_n rises, first arbitration occurs on the first rising edge with rst_n high.

Verification
REQ-033 RAM preloaded 90,80,...,10,100,101,102; A reads addr 3 alone -> ack_a in cycle N+2, rdata_a = 60, err_a = 0.
REQ-034 A writes 0x55 to addr 5, then B reads addr 5 -> ram_en one cycle high with ram_dir = 5; B gets rdata_b = 0x55.
REQ-035 A and B both hold req continuously (reads addr 0 and 9) from reset -> ack order A, B, A, B; rdata_a = 90, rdata_b = 100.
REQ-036 B writes addr 12 (DEPTH) -> ram_en stays 0, ack_b and err_b pulse together, RAM contents unchanged.
REQ-037 rst_n pulsed low during ACCESS of a write -> ram_en drops immediately, no ack, FSM in IDLE, next tie goes to A.
REQ-038 A changes addr_a after latch but before ack -> access uses original address.
